// File: rtl/sync_fifo_buf.sv
// rtl/sync_fifo_buf.sv - single-clock FIFO with registered read, level flags and sticky errors
// Optional: define SYNC_FIFO_PEAK_EN to add the peak_count high-water-mark output.
module sync_fifo_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
`ifdef SYNC_FIFO_PEAK_EN
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   peak_count
`else
  output logic                  underflow
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  rd_acc;
  logic                  wr_acc;

  // Accept decisions and next occupancy; a write at full rides on a same-cycle read.
  always_comb begin
    rd_acc    = rd_en & ~empty;
    wr_acc    = wr_en & (~full | rd_acc);
    count_nxt = count;
    if (wr_acc && !rd_acc) begin
      count_nxt = count + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count - 1'b1;
    end
  end

  // Storage array; deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  // Pointers, count, registered read port and flags derived from the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      // A new error in the clearing cycle wins over err_clr.
      overflow     <= (wr_en & ~wr_acc) | (overflow & ~err_clr);
      underflow    <= (rd_en & ~rd_acc) | (underflow & ~err_clr);
    end
  end

`ifdef SYNC_FIFO_PEAK_EN
  // High-water mark of occupancy; err_clr restarts it from the current level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_count <= '0;
    end else if (err_clr) begin
      peak_count <= count_nxt;
    end else if (count_nxt > peak_count) begin
      peak_count <= count_nxt;
    end
  end
`endif

  // Pointer distance (modulo 2*DEPTH) must always equal the occupancy register.
  ptr_count_consistent: assert property (@(posedge clk) disable iff (rst)
    (ADDR_WIDTH+1)'(wr_ptr - rd_ptr) == count);

endmodule
